// File: rtl/aes_dec_round_ctrl.sv
// Sequencer for an iterative AES inverse-cipher datapath and its round-key store.
// Handles key expansion into the (NR+1)-entry round-key RAM, then steps one ciphertext
// block at a time through AddRoundKey, NR-1 full inverse rounds and the final round.
// All datapath strobes are registered. They are decoded from the next state so that
// each one lines up with the state it belongs to. Only in_ready and st_load are
// combinational, because they must respond to the requester in the same cycle.
module aes_dec_round_ctrl #(
  parameter int unsigned NR      = 10,
  parameter int unsigned ROUND_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_valid,
  output logic               key_ack,
  output logic               key_ready,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               kld,
  output logic               rk_we,
  output logic [ROUND_W-1:0] rk_waddr,
  output logic [ROUND_W-1:0] rk_raddr,
  output logic               st_load,
  output logic               st_en,
  output logic [1:0]         dp_mode,
  output logic               busy
);

  typedef enum logic [2:0] {
    StIdle, StKload, StKexp, StKrdy, StArk, StRound, StLast, StOut
  } state_e;

  localparam logic [ROUND_W-1:0] LastIdx    = ROUND_W'(NR);
  localparam logic [ROUND_W-1:0] RoundStart = ROUND_W'(NR - 1);
  localparam logic [ROUND_W-1:0] OneIdx     = ROUND_W'(1);

  localparam logic [1:0] ModeIdle  = 2'b00;
  localparam logic [1:0] ModeArk   = 2'b01;
  localparam logic [1:0] ModeRound = 2'b10;
  localparam logic [1:0] ModeLast  = 2'b11;

  state_e             state_q, state_d;
  logic [ROUND_W-1:0] cnt_q, cnt_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic               key_ready_q, key_ready_d;

  logic               kld_q, kld_d;
  logic               rk_we_q, rk_we_d;
  logic [ROUND_W-1:0] rk_waddr_q, rk_waddr_d;
  logic [ROUND_W-1:0] rk_raddr_q, rk_raddr_d;
  logic               st_en_q, st_en_d;
  logic [1:0]         dp_mode_q, dp_mode_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  // Next state, counters and key_ready bookkeeping.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    round_d     = round_q;
    key_ready_d = key_ready_q;
    case (state_q)
      StIdle: begin
        if (key_valid) state_d = StKload;
      end
      StKload: begin
        key_ready_d = 1'b0;
        cnt_d       = '0;
        state_d     = StKexp;
      end
      StKexp: begin
        if (cnt_q == LastIdx) begin
          key_ready_d = 1'b1;
          cnt_d       = '0;
          state_d     = StKrdy;
        end else begin
          cnt_d = cnt_q + OneIdx;
        end
      end
      StKrdy: begin
        // A rekey request wins over a waiting block.
        if (key_valid) begin
          state_d = StKload;
        end else if (in_valid) begin
          state_d = StArk;
        end
      end
      StArk: begin
        round_d = RoundStart;
        state_d = StRound;
      end
      StRound: begin
        // Hold round at 1 on exit so it never leaves 1..NR-1.
        if (round_q == OneIdx) begin
          state_d = StLast;
        end else begin
          round_d = round_q - OneIdx;
        end
      end
      StLast: begin
        state_d = StOut;
      end
      StOut: begin
        if (out_ready) state_d = StKrdy;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Registered strobes decoded from the state being entered.
  always_comb begin
    kld_d       = 1'b0;
    rk_we_d     = 1'b0;
    rk_waddr_d  = '0;
    rk_raddr_d  = '0;
    st_en_d     = 1'b0;
    dp_mode_d   = ModeIdle;
    out_valid_d = 1'b0;
    busy_d      = 1'b1;
    case (state_d)
      StIdle, StKrdy: busy_d = 1'b0;
      StKload: kld_d = 1'b1;
      StKexp: begin
        rk_we_d    = 1'b1;
        rk_waddr_d = cnt_d;
      end
      StArk: begin
        dp_mode_d  = ModeArk;
        rk_raddr_d = LastIdx;
        st_en_d    = 1'b1;
      end
      StRound: begin
        dp_mode_d  = ModeRound;
        rk_raddr_d = round_d;
        st_en_d    = 1'b1;
      end
      StLast: begin
        dp_mode_d = ModeLast;
        st_en_d   = 1'b1;
      end
      StOut: out_valid_d = 1'b1;
      default: busy_d = 1'b0;
    endcase
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      round_q     <= '0;
      key_ready_q <= 1'b0;
      kld_q       <= 1'b0;
      rk_we_q     <= 1'b0;
      rk_waddr_q  <= '0;
      rk_raddr_q  <= '0;
      st_en_q     <= 1'b0;
      dp_mode_q   <= ModeIdle;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      round_q     <= round_d;
      key_ready_q <= key_ready_d;
      kld_q       <= kld_d;
      rk_we_q     <= rk_we_d;
      rk_waddr_q  <= rk_waddr_d;
      rk_raddr_q  <= rk_raddr_d;
      st_en_q     <= st_en_d;
      dp_mode_q   <= dp_mode_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Requester handshake must react to key_valid/in_valid within the cycle.
  always_comb begin
    in_ready = (state_q == StKrdy) && !key_valid;
    st_load  = in_ready && in_valid;
  end

  assign kld       = kld_q;
  assign key_ack   = kld_q;
  assign key_ready = key_ready_q;
  assign rk_we     = rk_we_q;
  assign rk_waddr  = rk_waddr_q;
  assign rk_raddr  = rk_raddr_q;
  assign st_en     = st_en_q;
  assign dp_mode   = dp_mode_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Bench for aes_dec_round_ctrl: an AES-128 datapath model driven by the DUT strobes,
// a phase-count protocol model checked every cycle, and directed plus random traffic.
module tb_aes_dec_round_ctrl;
  localparam int NR = 10;
  localparam int RW = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic key_valid = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic key_ack, key_ready, in_ready, out_valid, kld, rk_we, st_load, st_en, busy;
  logic [RW-1:0] rk_waddr, rk_raddr;
  logic [1:0] dp_mode;
  logic [127:0] key_in = '0, ct_in = '0;

  aes_dec_round_ctrl #(.NR(NR), .ROUND_W(RW)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_ack(key_ack),
    .key_ready(key_ready), .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .kld(kld), .rk_we(rk_we), .rk_waddr(rk_waddr),
    .rk_raddr(rk_raddr), .st_load(st_load), .st_en(st_en), .dp_mode(dp_mode), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0, n_out = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- AES-128 reference arithmetic ----------------
  logic [7:0] sbox [256];
  logic [7:0] inv_sbox [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] inv_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];    a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];    a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] aes_dec_ref(input logic [127:0] key, input logic [127:0] ct);
    logic [127:0] s;
    s = ct ^ round_key(key, NR);
    for (int r = NR - 1; r >= 1; r--) s = inv_mix(inv_sub(inv_shift(s)) ^ round_key(key, r));
    return inv_sub(inv_shift(s)) ^ round_key(key, 0);
  endfunction

  // ---------------- negedge samples of DUT and inputs ----------------
  logic s_kld, s_rk_we, s_st_load, s_st_en, s_out_valid, s_kv, s_iv, s_or;
  logic [RW-1:0] s_waddr, s_raddr;
  logic [1:0] s_mode;
  logic [127:0] s_key, s_ct;

  // ---------------- protocol model: phases since KLOAD / since accept ----------------
  int m_k = -1;       // 0 = key-load cycle, 1..NR+1 = schedule writes
  int m_b = -1;       // 1 = ARK, 2..NR = full rounds, NR+1 = final, NR+2 = output wait
  bit m_kready = 0;

  logic [127:0] cur_key = '0, dp_st = '0, last_pt = '0;
  logic [127:0] rk_ram [16];
  logic [127:0] exp_q [$];

  // Datapath and protocol model advance on each rising edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_k = -1; m_b = -1; m_kready = 0;
      exp_q.delete();
    end else begin
      if (s_kld) cur_key = s_key;
      if (s_rk_we) rk_ram[s_waddr] = round_key(cur_key, int'(s_waddr));
      if (s_st_load) begin
        dp_st = s_ct;
        exp_q.push_back(aes_dec_ref(cur_key, s_ct));
      end else if (s_st_en) begin
        case (s_mode)
          2'b01: dp_st = dp_st ^ rk_ram[s_raddr];
          2'b10: dp_st = inv_mix(inv_sub(inv_shift(dp_st)) ^ rk_ram[s_raddr]);
          2'b11: dp_st = inv_sub(inv_shift(dp_st)) ^ rk_ram[s_raddr];
          default: ;
        endcase
      end
      if (s_out_valid && s_or) begin
        chk("output_expected", 128'(exp_q.size() != 0), 128'd1);
        if (exp_q.size() != 0) chk("plaintext", dp_st, exp_q.pop_front());
        last_pt = dp_st;
        n_out++;
      end
      if (m_k >= 0) begin
        if (m_k == 0) m_kready = 0;
        m_k++;
        if (m_k > NR + 1) begin m_k = -1; m_kready = 1; end
      end else if (m_b >= 0) begin
        if (m_b == NR + 2) begin
          if (s_or) m_b = -1;
        end else m_b++;
      end else if (s_kv) m_k = 0;
      else if (m_kready && s_iv) m_b = 1;
    end
  end

  // Sample everything and compare every output against the model each cycle.
  always @(negedge clk) begin
    bit e_busy, e_we, e_ir;
    int e_wa, e_ra, e_mode;
    s_kld = kld; s_rk_we = rk_we; s_st_load = st_load; s_st_en = st_en;
    s_out_valid = out_valid; s_waddr = rk_waddr; s_raddr = rk_raddr; s_mode = dp_mode;
    s_kv = key_valid; s_iv = in_valid; s_or = out_ready; s_key = key_in; s_ct = ct_in;
    if (reset) begin
      e_busy = (m_k >= 0) || (m_b >= 0);
      e_we   = (m_k >= 1) && (m_k <= NR + 1);
      e_wa   = e_we ? m_k - 1 : 0;
      e_ir   = m_kready && !e_busy && !key_valid;
      e_mode = (m_b == 1) ? 1 : (m_b >= 2 && m_b <= NR) ? 2 : (m_b == NR + 1) ? 3 : 0;
      e_ra   = (m_b == 1) ? NR : (m_b >= 2 && m_b <= NR) ? NR + 1 - m_b : 0;
      chk("kld", kld, m_k == 0);
      chk("key_ack", key_ack, m_k == 0);
      chk("key_ready", key_ready, m_kready);
      chk("rk_we", rk_we, e_we);
      chk("rk_waddr", rk_waddr, e_wa);
      chk("in_ready", in_ready, e_ir);
      chk("st_load", st_load, e_ir && in_valid);
      chk("dp_mode", dp_mode, e_mode);
      chk("rk_raddr", rk_raddr, e_ra);
      chk("st_en", st_en, (m_b >= 1) && (m_b <= NR + 1));
      chk("out_valid", out_valid, m_b == NR + 2);
      chk("busy", busy, e_busy);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic load_key(input logic [127:0] k);
    bit got;
    tick;
    key_in = k;
    key_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (key_ack) begin got = 1; break; end
    end
    chk("key_ack_seen", got, 1);
    tick;
    key_valid = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] ct, output int acc_cyc);
    bit got;
    tick;
    ct_in = ct;
    in_valid = 1'b1;
    got = 0;
    acc_cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (st_load) begin got = 1; acc_cyc = cyc; break; end
    end
    chk("accept_seen", got, 1);
    tick;
    in_valid = 1'b0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  localparam logic [127:0] FipsKey = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FipsCt  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FipsPt  = 128'h00112233445566778899aabbccddeeff;

  initial begin
    int acc, n, base;
    bit got;
    int ra_exp [11];
    int mode_exp [11];
    int acc_t [10];
    ra_exp   = '{10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
    mode_exp = '{1, 2, 2, 2, 2, 2, 2, 2, 2, 2, 3};

    for (int x = 0; x < 256; x++) begin
      sbox[x] = affine(ginv(8'(x)));
      inv_sbox[sbox[x]] = 8'(x);
    end
    chk("model_fips_c1", aes_dec_ref(FipsKey, FipsCt), FipsPt);

    // Reset state.
    repeat (3) @(posedge clk);
    #2;
    chk("reset_outputs", {kld, key_ack, key_ready, in_ready, out_valid, rk_we, rk_waddr,
                          rk_raddr, st_load, st_en, dp_mode, busy}, '0);
    reset = 1'b1;

    // 1: key load and schedule writes 0..NR.
    load_key(FipsKey);
    for (int i = 0; i <= NR; i++) begin
      @(negedge clk);
      chk("t1_rk_we", rk_we, 1);
      chk("t1_rk_waddr", rk_waddr, i);
      chk("t1_key_ready_low", key_ready, 0);
    end
    @(negedge clk);
    chk("t1_key_ready_set", key_ready, 1);
    chk("t1_rk_we_done", rk_we, 0);

    // 2: FIPS-197 block, read-index and mode sequences, latency.
    send_block(FipsCt, acc);
    for (int j = 0; j < 11; j++) begin
      @(negedge clk);
      chk("t2_rk_raddr_seq", rk_raddr, ra_exp[j]);
      chk("t2_dp_mode_seq", dp_mode, mode_exp[j]);
    end
    @(negedge clk);
    chk("t2_out_valid_latency", out_valid, 1);
    tick;
    @(negedge clk);
    chk("t2_fips_plaintext", last_pt, FipsPt);

    // 3: output back-pressure for 5 cycles, taken on the 6th.
    tick;
    out_ready = 1'b0;
    send_block(rnd128(), acc);
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin got = 1; break; end
    end
    chk("t3_out_valid_seen", got, 1);
    base = n_out;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) @(negedge clk);
      chk("t3_hold_out_valid", out_valid, 1);
      chk("t3_hold_in_ready", in_ready, 0);
      chk("t3_hold_st_en", st_en, 0);
    end
    tick;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_out_valid_6th", out_valid, 1);
    tick;
    @(negedge clk);
    chk("t3_out_released", out_valid, 0);
    chk("t3_one_result", n_out, base + 1);

    // 4: key_valid and in_valid together in KRDY; rekey wins.
    tick;
    key_in = rnd128();
    key_valid = 1'b1;
    ct_in = rnd128();
    in_valid = 1'b1;
    @(negedge clk);
    chk("t4_in_ready_blocked", in_ready, 0);
    chk("t4_no_accept", st_load, 0);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (key_ack) begin got = 1; break; end
    end
    chk("t4_rekey_ack", got, 1);
    tick;
    key_valid = 1'b0;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (st_load) begin n = i; break; end
    end
    chk("t4_accept_after_schedule", n, 12);
    tick;
    in_valid = 1'b0;
    repeat (15) tick;

    // 5: asynchronous reset while round == 5.
    send_block(rnd128(), acc);
    got = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (dp_mode == 2'b10 && rk_raddr == 4'd5) begin got = 1; break; end
    end
    chk("t5_reached_round5", got, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_async_outputs", {kld, key_ack, key_ready, in_ready, out_valid, rk_we, rk_waddr,
                             rk_raddr, st_load, st_en, dp_mode, busy}, '0);
    in_valid = 1'b1;
    ct_in = rnd128();
    tick;
    tick;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_key_ready_cleared", key_ready, 0);
      chk("t5_in_ready_low", in_ready, 0);
      chk("t5_idle", busy, 0);
    end
    tick;
    in_valid = 1'b0;
    load_key(rnd128());
    repeat (13) tick;

    // 6: ten back-to-back blocks.
    base = n_out;
    ct_in = rnd128();
    in_valid = 1'b1;
    for (int b = 0; b < 10; b++) begin
      got = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (st_load) begin got = 1; break; end
      end
      chk("t6_accept_seen", got, 1);
      acc_t[b] = cyc;
      tick;
      ct_in = rnd128();
    end
    in_valid = 1'b0;
    for (int b = 1; b < 10; b++) chk("t6_accept_interval", acc_t[b] - acc_t[b-1], NR + 3);
    repeat (20) tick;
    chk("t6_ten_results", n_out, base + 10);

    // Random traffic: ragged valid/ready and occasional rekeys.
    for (int i = 0; i < 600; i++) begin
      tick;
      out_ready = ($urandom_range(0, 2) != 0);
      in_valid = $urandom_range(0, 1);
      ct_in = rnd128();
      if ($urandom_range(0, 59) == 0) begin
        key_valid = 1'b1;
        key_in = rnd128();
      end else begin
        key_valid = 1'b0;
      end
    end
    tick;
    in_valid = 1'b0;
    key_valid = 1'b0;
    out_ready = 1'b1;
    repeat (40) tick;
    chk("all_results_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
